// File: rtl/mem_master.sv
// mem_master: burst initiator for a single-port valid/ready memory.
//
// Takes a command (direction, base address, beat count), then runs one memory
// beat at a time. Write beats pull a word from the wd_* stream first; read
// beats push the returned word out on rd_* as a one-cycle pulse.
//
// Handshakes:
//   cmd_*  : a command transfers on a clock edge where cmd_valid && cmd_ready.
//   wd_*   : a write word transfers on a clock edge where wd_valid && wd_ready.
//   memory : return-to-zero. valid is raised and held with wr_rd/addr/wdata
//            stable until ready is seen high, then valid drops and the next
//            beat waits for ready to go low again. While waiting for either
//            ready level, a cycle counter aborts the burst after TIMEOUT
//            cycles (err held until the next accepted command).
//
// Ports:
//   clk, res                 clock, synchronous active-low reset
//   cmd_valid/ready/wr/addr/len   command interface
//   wd_valid/ready/data      write data input stream
//   rd_valid/data            read data output (one-cycle pulse)
//   busy, done, err          status (done pulses at burst end, err on timeout)
//   valid/wr_rd/addr/wdata   memory request, ready/rdata memory response
//   dbg_state                current FSM state (IDLE=0 WAIT_WD=1 REQ=2 GAP=3)
module mem_master #(
  parameter int WIDTH   = 8,
  parameter int ADDR_W  = 4,
  parameter int LEN_W   = 5,
  parameter int TIMEOUT = 15
) (
  input  logic              clk,
  input  logic              res,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic              cmd_wr,
  input  logic [ADDR_W-1:0] cmd_addr,
  input  logic [LEN_W-1:0]  cmd_len,
  input  logic              wd_valid,
  output logic              wd_ready,
  input  logic [WIDTH-1:0]  wd_data,
  output logic              rd_valid,
  output logic [WIDTH-1:0]  rd_data,
  output logic              busy,
  output logic              done,
  output logic              err,
  output logic              valid,
  output logic              wr_rd,
  output logic [ADDR_W-1:0] addr,
  output logic [WIDTH-1:0]  wdata,
  input  logic              ready,
  input  logic [WIDTH-1:0]  rdata,
  output logic [1:0]        dbg_state
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    WAIT_WD = 2'd1,
    REQ     = 2'd2,
    GAP     = 2'd3
  } state_e;

  localparam int TW = $clog2(TIMEOUT + 1);
  // Counter value at which the current waiting cycle is the TIMEOUT-th one.
  localparam logic [TW-1:0] TLIM = TW'(TIMEOUT - 1);

  state_e            state_q;
  logic              wr_q;
  logic [LEN_W-1:0]  rem_q;
  logic [TW-1:0]     tcnt_q;
  logic              valid_q, wr_rd_q, rd_valid_q, done_q, err_q, busy_q, wd_ready_q;
  logic [ADDR_W-1:0] addr_q;
  logic [WIDTH-1:0]  wdata_q, rd_data_q;

  // Held low while res is asserted so no command is taken during reset.
  assign cmd_ready = (state_q == IDLE) && res;

  assign valid     = valid_q;
  assign wr_rd     = wr_rd_q;
  assign addr      = addr_q;
  assign wdata     = wdata_q;
  assign rd_valid  = rd_valid_q;
  assign rd_data   = rd_data_q;
  assign done      = done_q;
  assign err       = err_q;
  assign busy      = busy_q;
  assign wd_ready  = wd_ready_q;
  assign dbg_state = state_q;

  always_ff @(posedge clk) begin
    if (!res) begin
      state_q    <= IDLE;
      wr_q       <= 1'b0;
      rem_q      <= '0;
      tcnt_q     <= '0;
      valid_q    <= 1'b0;
      wr_rd_q    <= 1'b0;
      addr_q     <= '0;
      wdata_q    <= '0;
      rd_valid_q <= 1'b0;
      rd_data_q  <= '0;
      done_q     <= 1'b0;
      err_q      <= 1'b0;
      busy_q     <= 1'b0;
      wd_ready_q <= 1'b0;
    end else begin
      rd_valid_q <= 1'b0;
      done_q     <= 1'b0;
      case (state_q)
        IDLE: begin
          if (cmd_valid) begin
            err_q  <= 1'b0;
            wr_q   <= cmd_wr;
            addr_q <= cmd_addr;
            rem_q  <= cmd_len;
            tcnt_q <= '0;
            if (cmd_len == '0) begin
              done_q <= 1'b1;
            end else if (cmd_wr) begin
              wd_ready_q <= 1'b1;
              busy_q     <= 1'b1;
              state_q    <= WAIT_WD;
            end else begin
              valid_q <= 1'b1;
              wr_rd_q <= 1'b0;
              busy_q  <= 1'b1;
              state_q <= REQ;
            end
          end
        end
        // Waiting on the producer is not a memory stall, so no timeout here.
        WAIT_WD: begin
          if (wd_valid) begin
            wd_ready_q <= 1'b0;
            wdata_q    <= wd_data;
            valid_q    <= 1'b1;
            wr_rd_q    <= 1'b1;
            tcnt_q     <= '0;
            state_q    <= REQ;
          end
        end
        REQ: begin
          if (ready) begin
            valid_q <= 1'b0;
            if (!wr_q) begin
              rd_data_q  <= rdata;
              rd_valid_q <= 1'b1;
            end
            rem_q   <= rem_q - 1'b1;
            addr_q  <= addr_q + 1'b1;
            tcnt_q  <= '0;
            state_q <= GAP;
          end else if (tcnt_q == TLIM) begin
            valid_q <= 1'b0;
            err_q   <= 1'b1;
            done_q  <= 1'b1;
            busy_q  <= 1'b0;
            state_q <= IDLE;
          end else begin
            tcnt_q <= tcnt_q + 1'b1;
          end
        end
        GAP: begin
          if (!ready) begin
            tcnt_q <= '0;
            if (rem_q == '0) begin
              done_q  <= 1'b1;
              busy_q  <= 1'b0;
              state_q <= IDLE;
            end else if (wr_q) begin
              wd_ready_q <= 1'b1;
              state_q    <= WAIT_WD;
            end else begin
              valid_q <= 1'b1;
              state_q <= REQ;
            end
          end else if (tcnt_q == TLIM) begin
            err_q   <= 1'b1;
            done_q  <= 1'b1;
            busy_q  <= 1'b0;
            state_q <= IDLE;
          end else begin
            tcnt_q <= tcnt_q + 1'b1;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

endmodule
